// File: rtl/alu_share_arbiter_if.sv
// Request, shared-ALU and response signals of the four-requester ALU arbiter.
// The slave side connects to the arbiter and the master side to its environment.
interface alu_share_arbiter_if #(
    parameter int unsigned N = 8
);
    logic [3:0]     req_valid;
    logic [3:0]     req_ready;
    logic [15:0]    req_op;
    logic [4*N-1:0] req_a;
    logic [4*N-1:0] req_b;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [3:0]     alu_sel;
    logic [N-1:0]   alu_y;
    logic           resp_valid;
    logic           resp_ready;
    logic [1:0]     resp_id;
    logic [N-1:0]   resp_data;
    logic           resp_err;
    logic           busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_y, resp_ready,
        output req_ready, alu_a, alu_b, alu_sel, resp_valid, resp_id, resp_data, resp_err, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_y, resp_ready,
        input  req_ready, alu_a, alu_b, alu_sel, resp_valid, resp_id, resp_data, resp_err, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among four requesters,
// with a single transaction in flight (IDLE -> EXEC -> RESP).
module alu_share_arbiter #(
    parameter int unsigned N = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_share_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state, state_nx;
    logic [1:0]   last_grant;
    logic [1:0]   lat_id;
    logic [3:0]   lat_op;
    logic [N-1:0] lat_a, lat_b;
    logic [1:0]   resp_id_r;
    logic [N-1:0] resp_data_r;
    logic         resp_err_r;

    logic         found;
    logic [1:0]   winner;
    logic         accept;
    logic         illegal_op;

    logic [3:0]   req_ready_c;
    logic [N-1:0] alu_a_c, alu_b_c;
    logic [3:0]   alu_sel_c;
    logic         resp_valid_c;

    // Rotating search: the requester just after the last grant is looked at first.
    always_comb begin
        logic [1:0] cand;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign accept     = (state == IDLE) && found;
    assign illegal_op = (lat_op > 4'd10);

    always_comb begin
        state_nx     = state;
        req_ready_c  = '0;
        alu_a_c      = '0;
        alu_b_c      = '0;
        alu_sel_c    = '1;
        resp_valid_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    req_ready_c[winner] = 1'b1;
                    state_nx            = EXEC;
                end
            end
            EXEC: begin
                alu_a_c   = lat_a;
                alu_b_c   = lat_b;
                alu_sel_c = lat_op;
                state_nx  = RESP;
            end
            RESP: begin
                resp_valid_c = 1'b1;
                if (bus.resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 2'd3;
            lat_id      <= '0;
            lat_op      <= '0;
            lat_a       <= '0;
            lat_b       <= '0;
            resp_id_r   <= '0;
            resp_data_r <= '0;
            resp_err_r  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                last_grant <= winner;
                lat_id     <= winner;
                lat_op     <= bus.req_op[4*winner +: 4];
                lat_a      <= bus.req_a[N*winner +: N];
                lat_b      <= bus.req_b[N*winner +: N];
            end
            if (state == EXEC) begin
                resp_id_r   <= lat_id;
                resp_err_r  <= illegal_op;
                resp_data_r <= illegal_op ? '0 : bus.alu_y;
            end
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.alu_a      = alu_a_c;
    assign bus.alu_b      = alu_b_c;
    assign bus.alu_sel    = alu_sel_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_id    = resp_id_r;
    assign bus.resp_data  = resp_data_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a transaction-level model predicts
// grants and responses, a separate monitor checks each response presented.
module tb_alu_share_arbiter;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    alu_share_arbiter_if #(.N(N)) bus();

    alu_share_arbiter #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] alu_ref(input logic [3:0] op, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        int sh;
        sh = int'(b) % N;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return ~(a | b);
            4'd5:    return a ^ b;
            4'd6:    return a << sh;
            4'd7:    return a >> sh;
            4'd8:    return N'($signed(a) >>> sh);
            4'd9:    return (a << sh) | (a >> (N - sh));
            4'd10:   return (a >> sh) | (a << (N - sh));
            default: return 8'hA5;
        endcase
    endfunction

    // Shared ALU model; illegal selectors return junk the arbiter must ignore.
    assign bus.alu_y = alu_ref(bus.alu_sel, bus.alu_a, bus.alu_b);

    function automatic int pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [1:0]   id;
        logic [N-1:0] data;
        logic         err;
        int           acc;
    } exp_t;

    exp_t q[$];
    bit   release_req = 1'b0;

    // Model: one transaction outstanding at most; freed the cycle after the handshake.
    initial begin
        bit           free;
        bit           exec_next;
        int           lg;
        int           w;
        logic [3:0]   ex_op;
        logic [N-1:0] ex_a, ex_b;
        exp_t         e;
        free = 1'b1;
        exec_next = 1'b0;
        lg = 3;
        ex_op = '0;
        ex_a = '0;
        ex_b = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                q.delete();
                free = 1'b1;
                exec_next = 1'b0;
                release_req = 1'b0;
                lg = 3;
            end else begin
                if (release_req) begin
                    free = 1'b1;
                    release_req = 1'b0;
                end
                chk("busy", 32'(bus.busy), 32'(!free));
                if (exec_next) begin
                    chk("alu_sel_exec", 32'(bus.alu_sel), 32'(ex_op));
                    chk("alu_a_exec", 32'(bus.alu_a), 32'(ex_a));
                    chk("alu_b_exec", 32'(bus.alu_b), 32'(ex_b));
                    exec_next = 1'b0;
                end else begin
                    chk("alu_sel_idle", 32'(bus.alu_sel), 32'hF);
                    chk("alu_a_idle", 32'(bus.alu_a), 32'h0);
                    chk("alu_b_idle", 32'(bus.alu_b), 32'h0);
                end
                if (free) begin
                    w = pick(bus.req_valid, lg);
                    chk("req_ready", 32'(bus.req_ready), (w < 0) ? 32'h0 : (32'h1 << w));
                    if (w >= 0) begin
                        ex_op = bus.req_op[4*w +: 4];
                        ex_a  = bus.req_a[N*w +: N];
                        ex_b  = bus.req_b[N*w +: N];
                        e.id   = 2'(w);
                        e.err  = (ex_op >= 4'd11);
                        e.data = e.err ? '0 : alu_ref(ex_op, ex_a, ex_b);
                        e.acc  = cyc;
                        q.push_back(e);
                        lg = w;
                        free = 1'b0;
                        exec_next = 1'b1;
                    end
                end else begin
                    chk("req_ready_busy", 32'(bus.req_ready), 32'h0);
                end
            end
        end
    end

    // Monitor: compares every presented response against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (bus.resp_valid) begin
                    chk("resp_expected", 32'(bus.resp_valid), 32'(q.size() != 0));
                    if (q.size() != 0) begin
                        e = q[0];
                        chk("resp_latency", 32'(cyc - e.acc >= 2), 32'h1);
                        chk("resp_id", 32'(bus.resp_id), 32'(e.id));
                        chk("resp_data", 32'(bus.resp_data), 32'(e.data));
                        chk("resp_err", 32'(bus.resp_err), 32'(e.err));
                        if (bus.resp_ready) begin
                            void'(q.pop_front());
                            release_req = 1'b1;
                        end
                    end
                end else if (q.size() != 0 && cyc - q[0].acc >= 2) begin
                    chk("resp_late", 32'(bus.resp_valid), 32'h1);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic [3:0] v, input logic [15:0] op,
                        input logic [4*N-1:0] a, input logic [4*N-1:0] b, input logic rr);
        @(negedge clk);
        reset          = rst;
        bus.req_valid  = v;
        bus.req_op     = op;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.resp_ready = rr;
    endtask

    task automatic rnd_step(input logic rst, input logic [3:0] v, input logic rr);
        step(rst, v, 16'($urandom), 32'($urandom), 32'($urandom), rr);
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        repeat (3) step(1'b1, 4'b0000, '0, '0, '0, 1'b1);
        repeat (2) step(1'b0, 4'b0000, '0, '0, '0, 1'b1);

        // Requester 1 alone: add 0x05 + 0x03.
        step(1'b0, 4'b0010, 16'h0000, 32'h0000_0500, 32'h0000_0300, 1'b1);
        repeat (4) step(1'b0, 4'b0000, '0, '0, '0, 1'b1);

        // Back-to-back contention from all requesters, consumer always ready.
        repeat (16) rnd_step(1'b0, 4'b1111, 1'b1);
        repeat (3) step(1'b0, 4'b0000, '0, '0, '0, 1'b1);

        // Requester 2 alone, then 0 and 3 together.
        step(1'b0, 4'b0100, 16'h0300, 32'h00F0_0000, 32'h0033_0000, 1'b1);
        repeat (3) step(1'b0, 4'b0000, '0, '0, '0, 1'b1);
        repeat (8) rnd_step(1'b0, 4'b1001, 1'b1);
        repeat (3) step(1'b0, 4'b0000, '0, '0, '0, 1'b1);

        // Stalled consumer with all requesters pending.
        step(1'b0, 4'b1111, 16'h5555, 32'h1122_3344, 32'h0F0F_0F0F, 1'b0);
        repeat (6) step(1'b0, 4'b1111, 16'h5555, 32'h1122_3344, 32'h0F0F_0F0F, 1'b0);
        repeat (4) step(1'b0, 4'b1111, 16'h5555, 32'h1122_3344, 32'h0F0F_0F0F, 1'b1);
        repeat (4) step(1'b0, 4'b0000, '0, '0, '0, 1'b1);

        // Illegal opcode from requester 0.
        step(1'b0, 4'b0001, 16'h000C, 32'h0000_00FF, 32'h0000_0001, 1'b1);
        repeat (4) step(1'b0, 4'b0000, '0, '0, '0, 1'b1);

        // Reset during EXEC abandons the transaction.
        step(1'b0, 4'b0001, 16'h0001, 32'h0000_0077, 32'h0000_0011, 1'b1);
        step(1'b1, 4'b0000, '0, '0, '0, 1'b1);
        repeat (4) step(1'b0, 4'b0000, '0, '0, '0, 1'b1);

        // Randomised traffic with occasional back-pressure and rare resets.
        repeat (400) rnd_step(1'b0 | ($urandom_range(0, 99) == 0), 4'($urandom),
                              ($urandom_range(0, 9) < 7));

        repeat (6) step(1'b0, 4'b0000, '0, '0, '0, 1'b1);
        @(negedge clk);
        #5;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
